mfm_rdat_gen: RTL and testbench
===============================

MFM_RDAT_GEN -- requirements
Module: mfm_rdat_gen

Purpose: drive-side read-data emulator. Serialises bytes as MFM flux-transition pulses on an active-low RDAT line for the VG93 read-data recovery front end.

Interface
REQ-001 Parameter HALFCELL, default 56: fclk cycles per MFM half-cell (2 us at 28 MHz).
REQ-002 Parameter PULSE_W, default 4: fclk cycles a transition pulse is held low.
REQ-003 Parameter FILL, default 8'h4E: byte sent on underrun.
REQ-004 fclk  in  1  single clock, 28 MHz; every register is clocked on posedge fclk.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 enable  in  1  read gate / motor on; low aborts all activity.
REQ-007 din  in  8  byte to transmit, MSB first.
REQ-008 din_mark  in  1  with din: suppress the clock of bit 2 (A1 sync mark, 0x4489).
REQ-009 din_valid  in  1  din/din_mark are valid.
REQ-010 din_ready  out  1  holding register can accept a byte.
REQ-011 rdat_n  out  1  registered, active-low flux-transition pulse.
REQ-012 busy  out  1  serialiser is in SHIFT state.
REQ-013 underrun  out  1  one-cycle pulse when FILL substitutes a missing byte.

Function
REQ-014 States: IDLE and SHIFT.
- Datapath: one holding register (byte, mark, full flag) and one shift register (byte, mark).
- Counters: bit index 7..0, phase (clock/data), half-cell counter 0..HALFCELL-1.
- prev_data bit.
REQ-015 din_ready = enable & ~hold_full; a byte is accepted on the edge where din_valid & din_ready.
REQ-016 IDLE -> SHIFT on the edge after the first accepted byte. That byte moves to the shift register with bit 7, clock phase and half-cell count 0. IDLE never signals underrun.
REQ-017 Half-cell counter increments each cycle in SHIFT and wraps at HALFCELL-1, toggling phase. Phase data->clock decrements the bit index; a byte lasts 16*HALFCELL cycles (896 by default).
REQ-018 Clock cell value = ~prev_data & ~cur_bit, except 0 when the mark is set and the bit index is 2. Data cell value = cur_bit. prev_data updates to cur_bit at the end of each data cell and carries across bytes.
REQ-019 rdat_n goes low on the edge after a cycle with half-cell count 0 and cell value 1, stays low exactly PULSE_W cycles, and is otherwise 1.
REQ-020 Byte boundary, meaning the last cycle of bit 0's data cell:
- If the holding register is full, its contents move to the shift register and hold_full clears.
- Else if din_valid is high that cycle, din/din_mark load directly into the shift register, with no underrun.
- Else FILL with mark=0 loads and underrun pulses for that one cycle.
REQ-021 A byte accepted on any non-boundary cycle goes to the holding register; din_ready drops the next cycle.
REQ-022 enable low in any state:
- next edge: state IDLE, rdat_n=1, counters 0, hold_full=0, din_ready=0;
- any pulse in progress is truncated;
- prev_data is kept.
REQ-023 Arithmetic: half-cell counter width is clog2(HALFCELL); pulse counter width is clog2(PULSE_W+1); no overflow is permitted for legal parameters (PULSE_W < HALFCELL).
REQ-024 busy = (state == SHIFT).

Reset
REQ-025 While rst is high, asynchronously: state IDLE, rdat_n=1, din_ready=0, busy=0, underrun=0, hold_full=0, all counters 0, prev_data=0, shift register 0.
REQ-026 rst asserted mid-pulse forces rdat_n=1 immediately. After release, behaviour resumes from IDLE only.

Verification
REQ-027 enable=1, send 0x00, prev_data=0 -> 8 pulses, each 4 cycles low, starting 1 cycle after half-cells 0,2,...,14 (112-cycle spacing); then underrun and FILL.
REQ-028 Send 0xFF -> 8 pulses on odd half-cells 1,3,...,15 only; none on clock cells.
REQ-029 Send 0x00 then A1 with din_mark=1 -> second byte's cell pattern is 0100010010001001 (0x4489). Same byte with mark=0 -> 0x44A9.
REQ-030 Send one byte, no further din_valid -> at cycle 896 underrun=1 for exactly 1 cycle and 0x4E is serialised; busy stays 1.
REQ-031 enable dropped in the 2nd cycle of a pulse -> rdat_n=1, busy=0, din_ready=0 on the next edge; no pulses afterwards.
REQ-032 Byte offered with din_valid only on the boundary cycle while the holding register is empty -> accepted into the shift register, no underrun pulse.

Source files
------------

// File: rtl/mfm_rdat_if.sv
// Byte-side handshake and drive-side read-data signals of the MFM read-data emulator.
// The master (byte source) offers bytes; the slave (serialiser) returns RDAT and status.
interface mfm_rdat_if;
    logic       enable;
    logic [7:0] din;
    logic       din_mark;
    logic       din_valid;
    logic       din_ready;
    logic       rdat_n;
    logic       busy;
    logic       underrun;

    modport master (
        output enable, din, din_mark, din_valid,
        input  din_ready, rdat_n, busy, underrun
    );

    modport slave (
        input  enable, din, din_mark, din_valid,
        output din_ready, rdat_n, busy, underrun
    );
endinterface

// File: rtl/mfm_rdat_gen.sv
// Drive-side read-data emulator: serialises bytes MSB first as MFM flux-transition
// pulses on active-low RDAT, with a one-byte holding register and FILL on underrun.
module mfm_rdat_gen #(
    parameter int         HALFCELL = 56,
    parameter int         PULSE_W  = 4,
    parameter logic [7:0] FILL     = 8'h4E
) (
    input  logic         fclk,
    input  logic         rst,
    mfm_rdat_if.slave    bus
);

    localparam int HC_W = (HALFCELL > 1) ? $clog2(HALFCELL) : 1;
    localparam int PC_W = $clog2(PULSE_W + 1);
    localparam logic [HC_W-1:0] HC_LAST = HC_W'(HALFCELL - 1);
    localparam logic [PC_W-1:0] PW_LAST = PC_W'(PULSE_W);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [7:0]      hold_byte_q, hold_byte_d;
    logic            hold_mark_q, hold_mark_d;
    logic            hold_full_q, hold_full_d;
    logic [7:0]      sh_byte_q, sh_byte_d;
    logic            sh_mark_q, sh_mark_d;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic            phase_q, phase_d;      // 0 = clock cell, 1 = data cell
    logic [HC_W-1:0] hc_q, hc_d;
    logic            prev_data_q, prev_data_d;
    logic [PC_W-1:0] pulse_cnt_q, pulse_cnt_d;
    logic            rdat_n_q, rdat_n_d;
    logic            underrun_q, underrun_d;
    logic            live_q;

    logic din_ready_w;
    logic accept;
    logic cur_bit;
    logic hc_wrap;
    logic boundary;
    logic cell_v;

    // MFM cell rule; the mark suppresses the clock of bit 2 to form the A1 sync pattern.
    function automatic logic cell_value(input logic       phase,
                                        input logic       cur,
                                        input logic       prev,
                                        input logic       mark,
                                        input logic [2:0] idx);
        if (phase) begin
            return cur;
        end
        if (mark && (idx == 3'd2)) begin
            return 1'b0;
        end
        return ~prev & ~cur;
    endfunction

    // live_q keeps din_ready low while reset is held without feeding rst into the datapath.
    assign din_ready_w = bus.enable & ~hold_full_q & live_q;
    assign accept      = bus.din_valid & din_ready_w;
    assign cur_bit     = sh_byte_q[bit_idx_q];
    assign hc_wrap     = (hc_q == HC_LAST);
    assign boundary    = (state_q == SHIFT) && phase_q && (bit_idx_q == 3'd0) && hc_wrap;
    assign cell_v      = cell_value(phase_q, cur_bit, prev_data_q, sh_mark_q, bit_idx_q);

    always_comb begin
        state_d     = state_q;
        hold_byte_d = hold_byte_q;
        hold_mark_d = hold_mark_q;
        hold_full_d = hold_full_q;
        sh_byte_d   = sh_byte_q;
        sh_mark_d   = sh_mark_q;
        bit_idx_d   = bit_idx_q;
        phase_d     = phase_q;
        hc_d        = hc_q;
        prev_data_d = prev_data_q;
        pulse_cnt_d = pulse_cnt_q;
        rdat_n_d    = rdat_n_q;
        underrun_d  = 1'b0;

        if (!rdat_n_q) begin
            if (pulse_cnt_q == PW_LAST) begin
                rdat_n_d    = 1'b1;
                pulse_cnt_d = '0;
            end else begin
                pulse_cnt_d = pulse_cnt_q + PC_W'(1);
            end
        end

        if (!bus.enable) begin
            state_d     = IDLE;
            rdat_n_d    = 1'b1;
            pulse_cnt_d = '0;
            hc_d        = '0;
            bit_idx_d   = '0;
            phase_d     = 1'b0;
            hold_full_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_d   = SHIFT;
                        sh_byte_d = bus.din;
                        sh_mark_d = bus.din_mark;
                        bit_idx_d = 3'd7;
                        phase_d   = 1'b0;
                        hc_d      = '0;
                    end
                end

                SHIFT: begin
                    if ((hc_q == '0) && cell_v) begin
                        rdat_n_d    = 1'b0;
                        pulse_cnt_d = PC_W'(1);
                    end

                    if (hc_wrap) begin
                        hc_d    = '0;
                        phase_d = ~phase_q;
                        if (phase_q) begin
                            prev_data_d = cur_bit;
                            bit_idx_d   = bit_idx_q - 3'd1;
                        end
                    end else begin
                        hc_d = hc_q + HC_W'(1);
                    end

                    if (boundary) begin
                        bit_idx_d = 3'd7;
                        if (hold_full_q) begin
                            sh_byte_d   = hold_byte_q;
                            sh_mark_d   = hold_mark_q;
                            hold_full_d = 1'b0;
                        end else if (bus.din_valid) begin
                            sh_byte_d = bus.din;
                            sh_mark_d = bus.din_mark;
                        end else begin
                            sh_byte_d  = FILL;
                            sh_mark_d  = 1'b0;
                            underrun_d = 1'b1;
                        end
                    end else if (accept) begin
                        hold_byte_d = bus.din;
                        hold_mark_d = bus.din_mark;
                        hold_full_d = 1'b1;
                    end
                end

                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge fclk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            hold_byte_q <= '0;
            hold_mark_q <= 1'b0;
            hold_full_q <= 1'b0;
            sh_byte_q   <= '0;
            sh_mark_q   <= 1'b0;
            bit_idx_q   <= '0;
            phase_q     <= 1'b0;
            hc_q        <= '0;
            prev_data_q <= 1'b0;
            pulse_cnt_q <= '0;
            rdat_n_q    <= 1'b1;
            underrun_q  <= 1'b0;
            live_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_byte_q <= hold_byte_d;
            hold_mark_q <= hold_mark_d;
            hold_full_q <= hold_full_d;
            sh_byte_q   <= sh_byte_d;
            sh_mark_q   <= sh_mark_d;
            bit_idx_q   <= bit_idx_d;
            phase_q     <= phase_d;
            hc_q        <= hc_d;
            prev_data_q <= prev_data_d;
            pulse_cnt_q <= pulse_cnt_d;
            rdat_n_q    <= rdat_n_d;
            underrun_q  <= underrun_d;
            live_q      <= 1'b1;
        end
    end

    assign bus.din_ready = din_ready_w;
    assign bus.rdat_n    = rdat_n_q;
    assign bus.busy      = (state_q == SHIFT);
    assign bus.underrun  = underrun_q;

endmodule

// File: tb/tb_mfm_rdat_gen.sv
// Scoreboard bench for mfm_rdat_gen: a cell-level MFM model predicts pulse start/width
// and underrun cycles per session; a negedge monitor pops and compares what RDAT shows.
module tb_mfm_rdat_gen;

    localparam int HC       = 56;
    localparam int PW       = 4;
    localparam int BYTE_CYC = 16 * HC;

    logic fclk = 1'b0;
    logic rst;
    int   cyc = 0;

    always #5 fclk = ~fclk;
    always @(posedge fclk) cyc <= cyc + 1;

    mfm_rdat_if bus ();

    mfm_rdat_gen #(
        .HALFCELL (HC),
        .PULSE_W  (PW),
        .FILL     (8'h4E)
    ) dut (
        .fclk (fclk),
        .rst  (rst),
        .bus  (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    int exp_ps[$];
    int exp_pw[$];
    int exp_ut[$];

    logic [7:0] plan_b[4];
    logic       plan_m[4];
    int         plan_n;
    logic       prev_model = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Serialised stream = planned bytes, then FILL bytes; cut off at abort cycle A.
    task automatic gen_expected(input int E, input int A);
        logic [7:0] byt;
        logic       mk;
        logic       bitv;
        logic       cv;
        int         cs;
        int         s;
        for (int k = 0; E + BYTE_CYC * k < A; k++) begin
            if (k < plan_n) begin
                byt = plan_b[k];
                mk  = plan_m[k];
            end else begin
                byt = 8'h4E;
                mk  = 1'b0;
                exp_ut.push_back(E + BYTE_CYC * k);
            end
            for (int i = 0; i < 8; i++) begin
                bitv = byt[7 - i];
                cs   = E + BYTE_CYC * k + 2 * HC * i;
                cv   = (!prev_model && !bitv) && !(mk && (7 - i) == 2);
                s    = cs + 1;
                if (cv && s < A) begin
                    exp_ps.push_back(s);
                    exp_pw.push_back((A - s < PW) ? A - s : PW);
                end
                cs = cs + HC;
                s  = cs + 1;
                if (bitv && s < A) begin
                    exp_ps.push_back(s);
                    exp_pw.push_back((A - s < PW) ? A - s : PW);
                end
                if (cs + HC - 1 <= A - 2) prev_model = bitv;
            end
        end
    endtask

    task automatic run_session(input int abort_off, input bit late, input bit by_reset);
        int   E;
        int   A;
        int   idx;
        logic rdy;
        @(negedge fclk);
        bus.enable    = 1'b1;
        bus.din       = plan_b[0];
        bus.din_mark  = plan_m[0];
        bus.din_valid = 1'b1;
        @(negedge fclk);
        E = cyc;
        A = E + abort_off;
        check("busy_after_first_byte", bus.busy, 1);
        gen_expected(E, A);
        idx = 1;
        if (late) begin
            bus.din_valid = 1'b0;
            while (cyc < E + BYTE_CYC - 1) @(negedge fclk);
            bus.din       = plan_b[1];
            bus.din_mark  = plan_m[1];
            bus.din_valid = 1'b1;
            @(negedge fclk);
            idx = 2;
        end else begin
            while (idx < plan_n && cyc < A - 2) begin
                bus.din       = plan_b[idx];
                bus.din_mark  = plan_m[idx];
                bus.din_valid = 1'b1;
                rdy           = bus.din_ready;
                @(negedge fclk);
                if (rdy) idx++;
            end
        end
        bus.din_valid = 1'b0;
        check("bytes_accepted", idx, plan_n);
        while (cyc < A - 1) @(negedge fclk);
        if (!by_reset) begin
            bus.enable = 1'b0;
            @(negedge fclk);
            check("rdat_n_after_disable", bus.rdat_n, 1);
            check("busy_after_disable", bus.busy, 0);
            check("din_ready_after_disable", bus.din_ready, 0);
        end else begin
            @(posedge fclk);
            #2 rst = 1'b1;
            #1 check("rdat_n_async_reset", bus.rdat_n, 1);
            bus.enable = 1'b0;
            prev_model = 1'b0;
            @(negedge fclk);
            check("busy_in_reset", bus.busy, 0);
            check("din_ready_in_reset", bus.din_ready, 0);
            @(negedge fclk);
            rst = 1'b0;
        end
        repeat (150) @(negedge fclk);
    endtask

    // Monitor: measures every RDAT low run and every underrun cycle.
    initial begin
        int   pstart;
        int   w;
        int   es;
        int   ew;
        int   eu;
        logic last_r;
        last_r = 1'b1;
        pstart = 0;
        forever begin
            @(negedge fclk);
            if (last_r === 1'b1 && bus.rdat_n === 1'b0) begin
                pstart = cyc;
            end else if (last_r === 1'b0 && bus.rdat_n === 1'b1) begin
                w = cyc - pstart;
                if (exp_ps.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_pulse: got start %0d width %0d, expected none", pstart, w);
                end else begin
                    es = exp_ps.pop_front();
                    ew = exp_pw.pop_front();
                    check("pulse_start", pstart, es);
                    check("pulse_width", w, ew);
                end
            end
            last_r = bus.rdat_n;
            if (bus.underrun === 1'b1) begin
                if (exp_ut.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_underrun: got pulse at cycle %0d, expected none", cyc);
                end else begin
                    eu = exp_ut.pop_front();
                    check("underrun_cycle", cyc, eu);
                    check("busy_at_underrun", bus.busy, 1);
                end
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1);
    end

    initial begin
        rst           = 1'b1;
        bus.enable    = 1'b1;
        bus.din       = 8'h00;
        bus.din_mark  = 1'b0;
        bus.din_valid = 1'b0;
        repeat (3) @(negedge fclk);
        check("reset_rdat_n", bus.rdat_n, 1);
        check("reset_din_ready", bus.din_ready, 0);
        check("reset_busy", bus.busy, 0);
        check("reset_underrun", bus.underrun, 0);
        rst        = 1'b0;
        bus.enable = 1'b0;
        repeat (5) @(negedge fclk);

        // 0x00: clock-cell pulses, then FILL with underrun
        plan_n = 1; plan_b[0] = 8'h00; plan_m[0] = 1'b0;
        run_session(2 * BYTE_CYC + 200, 1'b0, 1'b0);

        // 0xFF: data-cell pulses only
        plan_n = 1; plan_b[0] = 8'hFF; plan_m[0] = 1'b0;
        run_session(BYTE_CYC + 20, 1'b0, 1'b0);

        // 0x00 then A1 with and without the sync mark
        plan_n = 2; plan_b[0] = 8'h00; plan_m[0] = 1'b0; plan_b[1] = 8'hA1; plan_m[1] = 1'b1;
        run_session(2 * BYTE_CYC + 10, 1'b0, 1'b0);
        plan_n = 2; plan_b[0] = 8'h00; plan_m[0] = 1'b0; plan_b[1] = 8'hA1; plan_m[1] = 1'b0;
        run_session(2 * BYTE_CYC + 10, 1'b0, 1'b0);

        // second byte offered only on the boundary cycle
        plan_n = 2; plan_b[0] = 8'h5A; plan_m[0] = 1'b0; plan_b[1] = 8'hC3; plan_m[1] = 1'b0;
        run_session(2 * BYTE_CYC + 300, 1'b1, 1'b0);

        // enable dropped in the second low cycle of the first pulse
        plan_n = 1; plan_b[0] = 8'h00; plan_m[0] = 1'b0;
        run_session(3, 1'b0, 1'b0);

        // reset asserted mid-pulse
        plan_n = 1; plan_b[0] = 8'h00; plan_m[0] = 1'b0;
        run_session(2, 1'b0, 1'b1);

        for (int r = 0; r < 5; r++) begin
            plan_n = $urandom_range(1, 3);
            for (int j = 0; j < 4; j++) begin
                plan_b[j] = 8'($urandom);
                plan_m[j] = ($urandom_range(0, 3) == 0);
            end
            run_session(BYTE_CYC * plan_n + $urandom_range(0, 1200), 1'b0, 1'b0);
        end

        repeat (50) @(negedge fclk);
        check("pulse_queue_drained", exp_ps.size(), 0);
        check("underrun_queue_drained", exp_ut.size(), 0);
        check("rdat_n_idle_end", bus.rdat_n, 1);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
